ro_puf_eval: RTL and testbench

Parametrised ring-oscillator PUF evaluator that turns one start request into a multi-bit response. For each response bit it selects a pair of free-running ring oscillators and counts their rising edges in the `clk` domain over a programmable window. The bit records which oscillator of the pair is faster. It sits between the oscillator bank, which drives raw `ro_in` and is gated by `ro_en`, and the top-level pin logic.

---
 rtl/ro_puf_eval.sv | 135 +++++++++++++
 tb/tb_ro_puf_eval.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: compares rising-edge counts of selected oscillator pairs
// over a programmable window and assembles a multi-bit response with a tie mask.
module ro_puf_eval #(
  parameter int NUM_RO    = 32,
  parameter int SEL_W     = 5,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  parameter int RESP_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [2*SEL_W-1:0]     challenge,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [NUM_RO-1:0]      ro_in,
  output logic                   ro_en,
  output logic                   busy,
  output logic                   resp_valid,
  output logic [RESP_BITS-1:0]   response,
  output logic [RESP_BITS-1:0]   tie_mask
);

  localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int T_W = (WIN_W > 2) ? WIN_W : 3;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] COUNT   = 3'd2;
  localparam logic [2:0] COMPARE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]           state;
  logic [SEL_W-1:0]     sel_a, sel_b, idx_a, idx_b;
  logic [WIN_W-1:0]     win;
  logic [K_W-1:0]       k;
  logic [T_W-1:0]       tcnt;
  logic [CNT_W-1:0]     cnt_a, cnt_b;
  logic [2:0]           sync_a, sync_b;
  logic                 edge_a, edge_b;
  logic [RESP_BITS-1:0] resp_sh, tie_sh, resp_nx, tie_nx;
  logic                 last_bit, settle_end, count_end;

  always_comb begin
    idx_a      = sel_a + SEL_W'(k);
    idx_b      = sel_b + SEL_W'(k);
    // sync[0], sync[1] form the synchronizer; sync[2] is the previous sample
    edge_a     = sync_a[1] & ~sync_a[2];
    edge_b     = sync_b[1] & ~sync_b[2];
    resp_nx    = resp_sh;
    tie_nx     = tie_sh;
    resp_nx[k] = (cnt_a > cnt_b);
    tie_nx[k]  = (cnt_a == cnt_b);
    last_bit   = (k == K_W'(RESP_BITS - 1));
    settle_end = (tcnt == T_W'(3));
    count_end  = (tcnt == T_W'(win - WIN_W'(1)));
    busy       = (state == SETTLE) || (state == COUNT) || (state == COMPARE);
    ro_en      = ena && busy;
    resp_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_a    <= '0;
      sel_b    <= '0;
      win      <= '0;
      k        <= '0;
      tcnt     <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      sync_a   <= '0;
      sync_b   <= '0;
      resp_sh  <= '0;
      tie_sh   <= '0;
      response <= '0;
      tie_mask <= '0;
    end else begin
      sync_a <= {sync_a[1:0], ro_in[idx_a]};
      sync_b <= {sync_b[1:0], ro_in[idx_b]};
      if (!ena) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              sel_a <= challenge[SEL_W-1:0];
              sel_b <= challenge[2*SEL_W-1:SEL_W];
              win   <= (win_len == '0) ? WIN_W'(1) : win_len;
              k     <= '0;
              tcnt  <= '0;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            cnt_a <= '0;
            cnt_b <= '0;
            if (settle_end) begin
              tcnt  <= '0;
              state <= COUNT;
            end else begin
              tcnt <= tcnt + T_W'(1);
            end
          end
          COUNT: begin
            if (edge_a && (cnt_a != '1)) cnt_a <= cnt_a + CNT_W'(1);
            if (edge_b && (cnt_b != '1)) cnt_b <= cnt_b + CNT_W'(1);
            if (count_end) begin
              tcnt  <= '0;
              state <= COMPARE;
            end else begin
              tcnt <= tcnt + T_W'(1);
            end
          end
          COMPARE: begin
            resp_sh <= resp_nx;
            tie_sh  <= tie_nx;
            // Outputs load on entry to DONE so they are already valid while resp_valid is high
            if (last_bit) begin
              response <= resp_nx;
              tie_mask <= tie_nx;
              state    <= DONE;
            end else begin
              k     <= k + K_W'(1);
              state <= SETTLE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval: vector table of full runs plus abort, isolation and saturation sequences.
module tb_ro_puf_eval;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, start2;
  logic [9:0]  challenge, challenge2;
  logic [15:0] win_len, win_len2;
  logic [31:0] ro_in = '0, ro_in2 = '0;
  logic        ro_en, busy, resp_valid;
  logic [7:0]  response, tie_mask;
  logic        ro_en2, busy2, resp_valid2;
  logic [7:0]  response2, tie_mask2;

  logic [31:0] tcyc = '0;
  int unsigned m6 = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Even oscillators: period 4; odd: period 8 (main) or period 6 (saturation build)
  always @(negedge clk) begin
    tcyc = tcyc + 1;
    m6 = (m6 == 5) ? 0 : m6 + 1;
    for (int i = 0; i < 32; i++) begin
      ro_in[i]  = (i % 2 == 0) ? tcyc[1] : tcyc[2];
      ro_in2[i] = (i % 2 == 0) ? tcyc[1] : (m6 < 3);
    end
  end

  ro_puf_eval dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .challenge(challenge),
    .win_len(win_len), .ro_in(ro_in), .ro_en(ro_en), .busy(busy),
    .resp_valid(resp_valid), .response(response), .tie_mask(tie_mask)
  );

  ro_puf_eval #(.NUM_RO(32), .SEL_W(5), .CNT_W(4), .WIN_W(16), .RESP_BITS(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .challenge(challenge2),
    .win_len(win_len2), .ro_in(ro_in2), .ro_en(ro_en2), .busy(busy2),
    .resp_valid(resp_valid2), .response(response2), .tie_mask(tie_mask2)
  );

  typedef struct {
    logic [9:0]  ch;
    logic [15:0] wl;
    logic [7:0]  r;
    logic [7:0]  t;
    int          busy_n;
    int          valid_at;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle 1 is the interval right after the edge that samples start.
  task automatic run_main(input logic [9:0] ch, input logic [15:0] wl, input bit disturb,
                          output int busy_n, output int valid_at,
                          output logic [7:0] r, output logic [7:0] t, output int en_bad);
    repeat (2) @(negedge clk);
    challenge = ch;
    win_len   = wl;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; valid_at = -1; en_bad = 0; r = '0; t = '0;
    for (int c = 1; c <= 3000; c++) begin
      if (busy) busy_n++;
      if (ro_en !== busy) en_bad++;
      if (resp_valid) begin
        valid_at = c; r = response; t = tie_mask;
        break;
      end
      if (disturb && c == 100) begin
        start = 1'b1; challenge = 10'h0A5; win_len = 16'd3;
      end
      if (disturb && c == 101) start = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_sat(input logic [9:0] ch, input logic [15:0] wl,
                         output int busy_n, output int valid_at,
                         output logic [7:0] r, output logic [7:0] t);
    repeat (2) @(negedge clk);
    challenge2 = ch;
    win_len2   = wl;
    start2     = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    busy_n = 0; valid_at = -1; r = '0; t = '0;
    for (int c = 1; c <= 3000; c++) begin
      if (busy2) busy_n++;
      if (resp_valid2) begin
        valid_at = c; r = response2; t = tie_mask2;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watch_no_valid(input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
  endtask

  initial begin
    int bn, va, eb, seen;
    logic [7:0] r, t;

    vecs[0] = '{10'h020, 16'd64, 8'h55, 8'h00, 552, 553};
    vecs[1] = '{10'h3FE, 16'd64, 8'h55, 8'h00, 552, 553};
    vecs[2] = '{10'h0A5, 16'd32, 8'h00, 8'hFF, 296, 297};
    vecs[3] = '{10'h001, 16'd16, 8'hAA, 8'h00, 168, 169};
    vecs[4] = '{10'h040, 16'd20, 8'h00, 8'hFF, 200, 201};
    vecs[5] = '{10'h0A5, 16'd0,  8'h00, 8'hFF, 48,  49};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; start2 = 1'b0;
    challenge = '0; win_len = '0; challenge2 = '0; win_len2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_ro_en", ro_en, 0);
    check("reset_valid", resp_valid, 0);
    check("reset_response", response, 0);
    check("reset_tie", tie_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_main(vecs[i].ch, vecs[i].wl, 1'b0, bn, va, r, t, eb);
      check($sformatf("v%0d_response", i), r, vecs[i].r);
      check($sformatf("v%0d_tie", i), t, vecs[i].t);
      check($sformatf("v%0d_busy_cycles", i), bn, vecs[i].busy_n);
      check($sformatf("v%0d_valid_cycle", i), va, vecs[i].valid_at);
      check($sformatf("v%0d_ro_en_track", i), eb, 0);
    end

    // start asserted during the DONE cycle must be dropped
    start = 1'b1;
    @(posedge clk);
    #1 check("done_start_ignored", busy, 0);
    start = 1'b0;
    @(posedge clk);
    #1 check("done_start_no_queue", busy, 0);

    // Mid-run start pulse and input changes are ignored
    run_main(10'h020, 16'd64, 1'b1, bn, va, r, t, eb);
    check("iso_response", r, 8'h55);
    check("iso_tie", t, 8'h00);
    check("iso_valid_cycle", va, 553);

    // Synchronous reset at cycle 100 of a run
    repeat (2) @(negedge clk);
    challenge = 10'h020; win_len = 16'd64; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1 check("rst_pre_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ro_en", ro_en, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_response", response, 0);
    check("rst_tie", tie_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_valid(700, seen);
    check("rst_no_valid", seen, 0);

    // ena dropped mid-run keeps prior outputs
    run_main(10'h0A5, 16'd32, 1'b0, bn, va, r, t, eb);
    check("pre_ena_tie", t, 8'hFF);
    repeat (2) @(negedge clk);
    challenge = 10'h020; win_len = 16'd64; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    @(posedge clk);
    #1;
    check("ena_abort_busy", busy, 0);
    check("ena_abort_ro_en", ro_en, 0);
    @(negedge clk);
    ena = 1'b1;
    watch_no_valid(700, seen);
    check("ena_no_valid", seen, 0);
    check("ena_keep_response", response, 8'h00);
    check("ena_keep_tie", tie_mask, 8'hFF);
    run_main(10'h020, 16'd64, 1'b0, bn, va, r, t, eb);
    check("post_abort_response", r, 8'h55);
    check("post_abort_tie", t, 8'h00);
    check("post_abort_valid_cycle", va, 553);

    // 4-bit counters saturate at 15 for both oscillators
    run_sat(10'h020, 16'd200, bn, va, r, t);
    check("sat_response", r, 8'h00);
    check("sat_tie", t, 8'hFF);
    check("sat_busy_cycles", bn, 1640);
    check("sat_valid_cycle", va, 1641);
    run_sat(10'h020, 16'd0, bn, va, r, t);
    check("sat_w0_busy_cycles", bn, 48);
    check("sat_w0_valid_cycle", va, 49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
